// File: rtl/chunked_add_sub.sv
// chunked_add_sub
// Multi-cycle adder/subtractor for the 8086 ALU datapath. Each RUN cycle
// adds one CHUNK-bit slice of the operands with a bit-serial ripple, keeping
// the inter-chunk carry in a register. Supports ADD, ADC, SUB and SBB and
// produces the x86 arithmetic flags.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   start    request pulse, accepted in IDLE or DONE
//   sub      0 = add, 1 = subtract (latched on start)
//   use_cin  1 = include cin (ADC/SBB) (latched on start)
//   cin      incoming CF for ADC/SBB (latched on start)
//   a, b     operands (latched on start)
//   busy     high while the operation is running
//   done     one-cycle pulse; result and flags valid from this cycle on
//   result   sum or difference
//   cf, zf, sf, of, af, pf  x86 flags

module chunked_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             use_cin,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cf,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             af,
    output logic             pf
);

    localparam int NCHUNK    = WIDTH / CHUNK;
    localparam int IDXW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // Bit 3 (the nibble carry for AF) lives in this chunk at this local position.
    localparam int NIB_CHUNK = 3 / CHUNK;
    localparam int NIB_LOCAL = 3 % CHUNK;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [IDXW-1:0] NIB_IDX  = IDXW'(NIB_CHUNK);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    // Operand latches are shifted right one chunk per RUN cycle so the
    // active slice is always in the low CHUNK bits.
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic               nib_q, nib_d;
    // Partial sum assembles here; it is only copied to result_q on completion.
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cf_q, cf_d;
    logic               zf_q, zf_d;
    logic               sf_q, sf_d;
    logic               of_q, of_d;
    logic               af_q, af_d;
    logic               pf_q, pf_d;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   sum_chunk;
    logic               ripple;
    logic               c_into_top;
    logic               nib_here;
    logic               nib_now;
    logic               cin_eff;

    // Ripple adder for the current chunk. The carry entering the top bit of
    // the chunk is kept because on the last chunk it is the carry into the MSB
    // needed for OF.
    always_comb begin
        a_chunk    = a_q[CHUNK-1:0];
        b_chunk    = b_q[CHUNK-1:0] ^ {CHUNK{sub_q}};
        sum_chunk  = '0;
        ripple     = carry_q;
        c_into_top = 1'b0;
        nib_here   = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_into_top = ripple;
            end
            sum_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ ripple;
            ripple       = (a_chunk[i] & b_chunk[i]) | (ripple & (a_chunk[i] ^ b_chunk[i]));
            if (i == NIB_LOCAL) begin
                nib_here = ripple;
            end
        end
    end

    // Next-state and datapath control. Subtraction is a + ~b + 1, so the
    // initial carry is inverted and the final carries are inverted back into
    // borrows for CF and AF.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        nib_d    = nib_q;
        work_d   = work_q;
        result_d = result_q;
        cf_d     = cf_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        of_d     = of_q;
        af_d     = af_q;
        pf_d     = pf_q;
        cin_eff  = use_cin & cin;
        nib_now  = nib_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub ? ~cin_eff : cin_eff;
                    idx_d   = '0;
                    nib_d   = 1'b0;
                    work_d  = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d  = (work_q >> CHUNK) | (WIDTH'(sum_chunk) << (WIDTH - CHUNK));
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = ripple;
                idx_d   = idx_q + 1'b1;
                nib_now = (idx_q == NIB_IDX) ? nib_here : nib_q;
                nib_d   = nib_now;
                if (idx_q == LAST_IDX) begin
                    state_d  = DONE;
                    result_d = work_d;
                    cf_d     = ripple ^ sub_q;
                    af_d     = nib_now ^ sub_q;
                    of_d     = c_into_top ^ ripple;
                    sf_d     = work_d[WIDTH-1];
                    zf_d     = (work_d == '0);
                    pf_d     = ~^work_d[7:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and aborts a run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            nib_q    <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            of_q     <= 1'b0;
            af_q     <= 1'b0;
            pf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            nib_q    <= nib_d;
            work_q   <= work_d;
            result_q <= result_d;
            cf_q     <= cf_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            of_q     <= of_d;
            af_q     <= af_d;
            pf_q     <= pf_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cf     = cf_q;
    assign zf     = zf_q;
    assign sf     = sf_q;
    assign of     = of_q;
    assign af     = af_q;
    assign pf     = pf_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// tb_chunked_add_sub
// Self-checking bench for chunked_add_sub. Two instances share operands and
// reset: dut1 with CHUNK=4 (four RUN cycles) and dut2 with CHUNK=16 (one RUN
// cycle). Directed vectors come from a table; random operations are checked
// against a plain-arithmetic model of the x86 ADD/ADC/SUB/SBB flags.

module tb_chunked_add_sub;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start2;
    logic        sub;
    logic        useCin;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;

    logic        busy1, done1, cf1, zf1, sf1, of1, af1, pf1;
    logic [15:0] result1;
    logic        busy2, done2, cf2, zf2, sf2, of2, af2, pf2;
    logic [15:0] result2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [15:0] va;
        logic [15:0] vb;
        logic        vsub;
        logic        vuse;
        logic        vcin;
        logic [15:0] expRes;
        logic [5:0]  expFlags;   // {cf, zf, sf, of, af, pf}
    } vec_t;

    vec_t vecs[4];

    chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut1 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .use_cin(useCin), .cin(cin),
        .a(a), .b(b), .busy(busy1), .done(done1), .result(result1),
        .cf(cf1), .zf(zf1), .sf(sf1), .of(of1), .af(af1), .pf(pf1)
    );

    chunked_add_sub #(.WIDTH(16), .CHUNK(16)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .sub(sub), .use_cin(useCin), .cin(cin),
        .a(a), .b(b), .busy(busy2), .done(done2), .result(result2),
        .cf(cf2), .zf(zf2), .sf(sf2), .of(of2), .af(af2), .pf(pf2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: {result[15:0], cf, zf, sf, of, af, pf} from integer arithmetic.
    function automatic logic [21:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic msub, input logic muse, input logic mcin);
        int          c;
        int          full;
        logic [15:0] r;
        logic        fcf, faf, fof;
        c = (muse & mcin) ? 1 : 0;
        if (!msub) begin
            full = int'(ma) + int'(mb) + c;
            fcf  = (full > 65535);
            faf  = (int'(ma[3:0]) + int'(mb[3:0]) + c) > 15;
        end else begin
            full = int'(ma) - int'(mb) - c;
            fcf  = (full < 0);
            faf  = (int'(ma[3:0]) - int'(mb[3:0]) - c) < 0;
        end
        r   = full[15:0];
        fof = msub ? ((ma[15] != mb[15]) && (r[15] != ma[15]))
                   : ((ma[15] == mb[15]) && (r[15] != ma[15]));
        return {r, fcf, (r == 16'h0000), r[15], fof, faf, ~^r[7:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one operation on dut1 (wide=0) or dut2 (wide=1), scrambles the
    // operand inputs after the start edge, and returns at the negedge where
    // done is seen (or after the cycle budget runs out).
    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tsub, input logic tuse, input logic tcin,
                                 input bit wide, output int busyCnt, output bit gotDone);
        @(negedge clk);
        a = ta; b = tb; sub = tsub; useCin = tuse; cin = tcin;
        if (wide) start2 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; start2 = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        sub = 1'($urandom); useCin = 1'($urandom); cin = 1'($urandom);
        busyCnt = 0;
        gotDone = 1'b0;
        for (int k = 0; k < 40 && !gotDone; k++) begin
            @(negedge clk);
            if (wide ? done2 : done1) gotDone = 1'b1;
            else if (wide ? busy2 : busy1) busyCnt++;
        end
    endtask

    task automatic runAndCheck(input string name, input logic [15:0] ta, input logic [15:0] tb,
                               input logic tsub, input logic tuse, input logic tcin,
                               input bit wide, input logic [15:0] expRes, input logic [5:0] expFlags);
        int busyCnt;
        bit gotDone;
        applyStimulus(ta, tb, tsub, tuse, tcin, wide, busyCnt, gotDone);
        checkOutput({name, " done seen"}, 32'(gotDone), 32'd1);
        checkOutput({name, " busy cycles"}, 32'(busyCnt), wide ? 32'd1 : 32'd4);
        if (wide) begin
            checkOutput({name, " result"}, 32'(result2), 32'(expRes));
            checkOutput({name, " flags"}, 32'({cf2, zf2, sf2, of2, af2, pf2}), 32'(expFlags));
        end else begin
            checkOutput({name, " result"}, 32'(result1), 32'(expRes));
            checkOutput({name, " flags"}, 32'({cf1, zf1, sf1, of1, af1, pf1}), 32'(expFlags));
        end
        @(negedge clk);
        checkOutput({name, " done pulse"}, 32'(wide ? done2 : done1), 32'd0);
    endtask

    initial begin
        int          busyCnt;
        bit          gotDone;
        bit          sawDone;
        logic [21:0] m;
        logic [15:0] ra, rb;
        logic        rs, ru, rc;

        vecs[0] = '{"ADD 7FFF+1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 6'b001111};
        vecs[1] = '{"SUB 0-1",      16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'hFFFF, 6'b101011};
        vecs[2] = '{"ADC FFFF+0+1", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 6'b110011};
        vecs[3] = '{"SBB 8000-1-1", 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h7FFE, 6'b000110};

        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        sub = 1'b0; useCin = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset dut1 busy/done", 32'({busy1, done1}), 32'd0);
        checkOutput("reset dut1 result", 32'(result1), 32'd0);
        checkOutput("reset dut1 flags", 32'({cf1, zf1, sf1, of1, af1, pf1}), 32'd0);
        checkOutput("reset dut2 outputs", 32'({busy2, done2, result2, cf2, zf2, sf2, of2, af2, pf2}), 32'd0);

        $display("[TB] directed table");
        for (int i = 0; i < 4; i++) begin
            runAndCheck(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].vuse,
                        vecs[i].vcin, 1'b0, vecs[i].expRes, vecs[i].expFlags);
        end
        runAndCheck("wide ADD 7FFF+1", vecs[0].va, vecs[0].vb, 1'b0, 1'b0, 1'b0, 1'b1,
                    vecs[0].expRes, vecs[0].expFlags);

        $display("[TB] start during RUN");
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; useCin = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        busyCnt = busy1 ? 1 : 0;
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        gotDone = 1'b0;
        for (int k = 0; k < 40 && !gotDone; k++) begin
            @(negedge clk);
            if (done1) gotDone = 1'b1;
            else if (busy1) busyCnt++;
        end
        checkOutput("midrun done seen", 32'(gotDone), 32'd1);
        checkOutput("midrun busy cycles", 32'(busyCnt), 32'd4);
        checkOutput("midrun result", 32'(result1), 32'h2345);
        @(negedge clk);
        checkOutput("midrun no queued op", 32'({busy1, done1}), 32'd0);

        $display("[TB] start in DONE cycle");
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, busyCnt, gotDone);
        checkOutput("b2b first done", 32'(gotDone), 32'd1);
        checkOutput("b2b first result", 32'(result1), 32'h0100);
        a = 16'h5000; b = 16'h6000; sub = 1'b1; useCin = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("b2b restart busy/done", 32'({busy1, done1}), 32'b10);
        checkOutput("b2b result held", 32'(result1), 32'h0100);
        busyCnt = 1;
        gotDone = 1'b0;
        for (int k = 0; k < 40 && !gotDone; k++) begin
            @(negedge clk);
            if (done1) gotDone = 1'b1;
            else if (busy1) busyCnt++;
        end
        m = model(16'h5000, 16'h6000, 1'b1, 1'b0, 1'b0);
        checkOutput("b2b second busy cycles", 32'(busyCnt), 32'd4);
        checkOutput("b2b second result", 32'(result1), 32'(m[21:6]));
        checkOutput("b2b second flags", 32'({cf1, zf1, sf1, of1, af1, pf1}), 32'(m[5:0]));

        $display("[TB] reset during RUN");
        @(negedge clk);
        a = 16'h7FFF; b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort busy before reset", 32'(busy1), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abort busy/done", 32'({busy1, done1}), 32'd0);
        checkOutput("abort result", 32'(result1), 32'd0);
        checkOutput("abort flags", 32'({cf1, zf1, sf1, of1, af1, pf1}), 32'd0);
        sawDone = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done1 || busy1) sawDone = 1'b1;
        end
        checkOutput("abort no done", 32'(sawDone), 32'd0);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            if (i % 8 == 0) rb = ra;
            rs = 1'($urandom); ru = 1'($urandom); rc = 1'($urandom);
            m = model(ra, rb, rs, ru, rc);
            runAndCheck("rand4", ra, rb, rs, ru, rc, 1'b0, m[21:6], m[5:0]);
        end
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rs = 1'($urandom); ru = 1'($urandom); rc = 1'($urandom);
            m = model(ra, rb, rs, ru, rc);
            runAndCheck("rand16", ra, rb, rs, ru, rc, 1'b1, m[21:6], m[5:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
